mmu_systolic_4x4: RTL and testbench

// - Weight-stationary 4x4 systolic matrix-multiply unit (TPU-style MMU core).
// - Weights are shifted in row by row, then skewed activation vectors stream
//   in from the left. Partial sums flow down, and column results exit at the

---
 rtl/mmu_systolic_4x4_if.sv | 16 +
 rtl/mmu_systolic_4x4.sv | 128 ++++++++++++
 tb/tb_mmu_systolic_4x4.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mmu_systolic_4x4_if.sv
// Bus interface for the 4x4 weight-stationary systolic MMU.
// The master drives mode, activation and weight words; the slave returns the
// bottom-row column sums.
interface mmu_systolic_4x4_if #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int AW = 32
);
    logic            control;   // 1 = weight load, 0 = compute
    logic [N*DW-1:0] data_arr;  // byte i feeds row i
    logic [N*DW-1:0] wt_arr;    // byte j feeds column j of row 0
    logic [N*AW-1:0] acc_out;   // [AW*j+:AW] = column j result

    modport master (output control, output data_arr, output wt_arr, input acc_out);
    modport slave  (input control, input data_arr, input wt_arr, output acc_out);
endinterface

// File: rtl/mmu_systolic_4x4.sv
// Weight-stationary 4x4 systolic matrix-multiply unit.
// Weights shift down row by row in load mode; skewed activations stream in
// from the left in compute mode and partial sums flow down to acc_out.
// Optional feature macro: MMU_SIGNED_EN (signed two's-complement operands,
// products sign-extended before accumulation). Default is unsigned.

module mmu_systolic_4x4_pe #(
    parameter int DW = 8,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ctrl_i,
    input  logic [DW-1:0] w_i,
    input  logic [DW-1:0] d_i,
    input  logic [AW-1:0] p_i,
    output logic [DW-1:0] w_o,
    output logic [DW-1:0] d_o,
    output logic [AW-1:0] p_o
);
    logic [DW-1:0] w_q, w_d;
    logic [DW-1:0] d_q, d_d;
    logic [AW-1:0] p_q, p_d;
    logic [AW-1:0] prod_ext;

`ifdef MMU_SIGNED_EN
    logic signed [2*DW-1:0] prod;
    assign prod     = $signed(d_i) * $signed(w_q);
    assign prod_ext = {{(AW-2*DW){prod[2*DW-1]}}, prod};
`else
    logic [2*DW-1:0] prod;
    assign prod     = d_i * w_q;
    assign prod_ext = {{(AW-2*DW){1'b0}}, prod};
`endif

    // Next state: load shifts weights and flushes the datapath; compute MACs.
    always_comb begin
        w_d = w_q;
        d_d = d_q;
        p_d = p_q;
        if (ctrl_i) begin
            w_d = w_i;
            d_d = '0;
            p_d = '0;
        end else begin
            d_d = d_i;
            p_d = p_i + prod_ext;
        end
    end

    // PE state registers; reset clears weights as well as the datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q <= '0;
            d_q <= '0;
            p_q <= '0;
        end else begin
            w_q <= w_d;
            d_q <= d_d;
            p_q <= p_d;
        end
    end

    assign w_o = w_q;
    assign d_o = d_q;
    assign p_o = p_q;
endmodule

module mmu_systolic_4x4 #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int AW = 32
) (
    input logic          clk,
    input logic          rst_n,
    mmu_systolic_4x4_if.slave bus
);
    logic [N-1:0][N-1:0][DW-1:0] w_a;
    logic [N-1:0][N-1:0][DW-1:0] d_a;
    logic [N-1:0][N-1:0][AW-1:0] p_a;

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [DW-1:0] w_in, d_in;
            logic [AW-1:0] p_in;

            // Weights enter at row 0 and shift down; psums start at 0 on top.
            if (i == 0) begin : g_top
                assign w_in = bus.wt_arr[DW*j +: DW];
                assign p_in = '0;
            end else begin : g_inner
                assign w_in = w_a[i-1][j];
                assign p_in = p_a[i-1][j];
            end

            // Activations enter at column 0 and march right.
            if (j == 0) begin : g_left
                assign d_in = bus.data_arr[DW*i +: DW];
            end else begin : g_mid
                assign d_in = d_a[i][j-1];
            end

            mmu_systolic_4x4_pe #(.DW(DW), .AW(AW)) u_pe (
                .clk    (clk),
                .rst_n  (rst_n),
                .ctrl_i (bus.control),
                .w_i    (w_in),
                .d_i    (d_in),
                .p_i    (p_in),
                .w_o    (w_a[i][j]),
                .d_o    (d_a[i][j]),
                .p_o    (p_a[i][j])
            );
        end
    end

    // Bottom-row psums are the registered column results.
    for (genvar j = 0; j < N; j++) begin : g_out
        assign bus.acc_out[AW*j +: AW] = p_a[N-1][j];
    end

    // Last-row weights and last-column activations have no consumer.
    logic unused_tail;
    always_comb begin
        unused_tail = ^w_a[N-1];
        for (int i = 0; i < N; i++) unused_tail = unused_tail ^ (^d_a[i][N-1]);
    end
endmodule

// File: tb/tb_mmu_systolic_4x4.sv
// Self-checking bench for mmu_systolic_4x4: directed table, disruption
// sequences, and random streaming against a matrix-product reference.
module tb_mmu_systolic_4x4;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    mmu_systolic_4x4_if #(.N(4), .DW(8), .AW(32)) bus ();

    mmu_systolic_4x4 #(.N(4), .DW(8), .AW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][31:0] wt;   // wt[k] = k-th load word
        logic [3:0][7:0]  x;    // activation vector
        logic [3:0][31:0] exp;  // expected column results
    } vec_t;

    vec_t tbl [4];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h expected %h", nm, idx, act, exp);
        end
    endtask

    function automatic logic [31:0] col(input int j);
        return bus.acc_out[32*j +: 32];
    endfunction

    // Product of one activation and one weight as the spec defines it.
    function automatic int mac(input logic [7:0] a, input logic [7:0] b);
        int sa, sb;
`ifdef MMU_SIGNED_EN
        sa = int'($signed(a));
        sb = int'($signed(b));
`else
        sa = int'(a);
        sb = int'(b);
`endif
        return sa * sb;
    endfunction

    task automatic load(input logic [3:0][31:0] w);
        bus.control = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.wt_arr = w[k];
            tick();
        end
        bus.control = 1'b0;
    endtask

    // Feed one skewed vector and check every column on every edge.
    task automatic run_vec(input int id, input vec_t v);
        logic [31:0] d;
        bus.control = 1'b0;
        for (int e = 0; e < 9; e++) begin
            d = '0;
            for (int i = 0; i < 4; i++) if (e == i) d[8*i +: 8] = v.x[i];
            bus.data_arr = d;
            tick();
            for (int j = 0; j < 4; j++)
                chk($sformatf("vec%0d_e%0d_col", id, e), j, col(j), (e == 3 + j) ? v.exp[j] : 32'h0);
        end
        bus.data_arr = '0;
    endtask

    initial begin
        logic [7:0]  xs [12][4];
        logic [7:0]  wm [4][4];
        logic [3:0][31:0] rw;
        logic [31:0] d, e32;
        int          s;

        // Directed table
        tbl[0].wt = {32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101};
        tbl[0].x  = {8'd1, 8'd1, 8'd1, 8'd1};
        tbl[0].exp = {32'd4, 32'd4, 32'd4, 32'd4};
        tbl[1].wt = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        tbl[1].x  = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
`ifdef MMU_SIGNED_EN
        tbl[1].exp = {32'd4, 32'd4, 32'd4, 32'd4};
`else
        tbl[1].exp = {32'h0003F804, 32'h0003F804, 32'h0003F804, 32'h0003F804};
`endif
        tbl[2].wt = {32'h100F0E0D, 32'h0C0B0A09, 32'h08070605, 32'h04030201};
        tbl[2].x  = {8'd4, 8'd3, 8'd2, 8'd1};
        tbl[2].exp = {32'd80, 32'd70, 32'd60, 32'd50};
        tbl[3].wt = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        tbl[3].x  = {8'd1, 8'd1, 8'd1, 8'd1};
`ifdef MMU_SIGNED_EN
        tbl[3].exp = {32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC};
`else
        tbl[3].exp = {32'h000003FC, 32'h000003FC, 32'h000003FC, 32'h000003FC};
`endif

        // Reset with random inputs: outputs held at zero
        rst_n = 1'b0;
        bus.control = 1'b0;
        bus.data_arr = '0;
        bus.wt_arr = '0;
        #1;
        chk("reset_imm", 0, bus.acc_out[31:0] | bus.acc_out[63:32] | bus.acc_out[95:64] | bus.acc_out[127:96], 32'h0);
        for (int c = 0; c < 4; c++) begin
            bus.control  = 1'($urandom_range(0, 1));
            bus.data_arr = $urandom;
            bus.wt_arr   = $urandom;
            tick();
            for (int j = 0; j < 4; j++) chk("reset_hold", j, col(j), 32'h0);
        end
        rst_n = 1'b1;
        bus.control = 1'b0;
        bus.data_arr = '0;

        // Table-driven vectors
        for (int t = 0; t < 4; t++) begin
            load(tbl[t].wt);
            run_vec(t, tbl[t]);
        end

        // Load asserted one edge after vector start flushes in-flight sums
        load(tbl[0].wt);
        bus.data_arr = 32'h00000001;
        tick();
        bus.control = 1'b1;
        bus.wt_arr  = 32'h01010101;
        bus.data_arr = 32'h00000100;
        tick();
        for (int j = 0; j < 4; j++) chk("flush_load", j, col(j), 32'h0);
        bus.control = 1'b0;
        bus.data_arr = '0;
        for (int e = 0; e < 7; e++) begin
            tick();
            for (int j = 0; j < 4; j++) chk("flush_after", j, col(j), 32'h0);
        end

        // Reset mid-vector clears outputs asynchronously and wipes weights
        load(tbl[0].wt);
        for (int e = 0; e < 4; e++) begin
            bus.data_arr = 32'h1 << (8 * e);
            tick();
        end
        chk("pre_rst_col0", 0, col(0), 32'd4);
        rst_n = 1'b0;
        #1;
        for (int j = 0; j < 4; j++) chk("async_rst", j, col(j), 32'h0);
        tick();
        rst_n = 1'b1;
        for (int e = 0; e < 8; e++) begin
            bus.data_arr = (e < 4) ? (32'h1 << (8 * e)) : 32'h0;
            tick();
            for (int j = 0; j < 4; j++) chk("wt_cleared", j, col(j), 32'h0);
        end

        // Random back-to-back streaming against C = X * W
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) rw[k] = $urandom;
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) wm[i][j] = rw[3-i][8*j +: 8];
            for (int v = 0; v < 12; v++)
                for (int i = 0; i < 4; i++) xs[v][i] = 8'($urandom);
            load(rw);
            for (int e = 0; e < 19; e++) begin
                d = '0;
                for (int i = 0; i < 4; i++)
                    if (e - i >= 0 && e - i < 12) d[8*i +: 8] = xs[e-i][i];
                bus.data_arr = d;
                tick();
                for (int j = 0; j < 4; j++) begin
                    s = e - 3 - j;
                    e32 = '0;
                    if (s >= 0 && s < 12)
                        for (int i = 0; i < 4; i++) e32 = e32 + 32'(mac(xs[s][i], wm[i][j]));
                    chk($sformatf("rand%0d_e%0d_col", r, e), j, col(j), e32);
                end
            end
            bus.data_arr = '0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
